// File: rtl/occ_table_responder.sv
// occ_table_responder: writable Occ table with multi-cycle miss fetch and a one-entry last-address cache
//   clk, rst                  : clock, asynchronous active-high reset
//   ce, addr                  : read request and address, held by the initiator until data is consumed
//   data, valid               : read data and level-valid for the current addr
//   busy                      : miss fetch in progress
//   wr_en, wr_addr, wr_data   : random table write port, accepted in every state
//   hit_cnt                   : saturating count of cache-served requests
module occ_table_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       hit_cnt
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    localparam logic [3:0] RELOAD = 4'(LATENCY - 1);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0] cache_data_q, cache_data_d;
    logic              cache_vld_q, cache_vld_d;
    logic              hit, wr_cap, new_req;
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_addr_q   <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            hit_cnt_q    <= '0;
            cache_addr_q <= '0;
            cache_data_q <= '0;
            cache_vld_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_addr_q   <= cap_addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            hit_cnt_q    <= hit_cnt_d;
            cache_addr_q <= cache_addr_d;
            cache_data_q <= cache_data_d;
            cache_vld_q  <= cache_vld_d;
        end
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_addr_d   = cap_addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        hit_cnt_d    = hit_cnt_q;
        cache_addr_d = cache_addr_q;
        cache_data_d = cache_data_q;
        cache_vld_d  = cache_vld_q;
        hit          = cache_vld_q && addr == cache_addr_q;
        wr_cap       = wr_en && wr_addr == cap_addr_q;
        new_req      = 1'b0;
        case (state_q)
            IDLE: new_req = ce;
            FETCH:
                if (!ce) state_d = IDLE;
                else if (addr != cap_addr_q) new_req = 1'b1;
                else if (wr_cap) cnt_d = RELOAD;
                else if (cnt_q == 4'd0) begin
                    data_d       = mem[cap_addr_q];
                    valid_d      = 1'b1;
                    cache_addr_d = cap_addr_q;
                    cache_data_d = mem[cap_addr_q];
                    cache_vld_d  = 1'b1;
                    state_d      = HOLD;
                end else cnt_d = cnt_q - 4'd1;
            HOLD:
                if (!ce) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (addr != cap_addr_q) new_req = 1'b1;
                else if (wr_cap) data_d = wr_data;
            default: state_d = IDLE;
        endcase
        // Shared request path for IDLE, FETCH restart and HOLD address switch
        if (new_req) begin
            cap_addr_d = addr;
            if (hit) begin
                // A same-edge write to the hit address supersedes the cached copy
                data_d    = (wr_en && wr_addr == addr) ? wr_data : cache_data_q;
                valid_d   = 1'b1;
                hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                state_d   = HOLD;
            end else begin
                valid_d = 1'b0;
                cnt_d   = RELOAD;
                state_d = FETCH;
            end
        end
        // Write-through applied after any fill so the written value wins
        if (cache_vld_d && wr_en && wr_addr == cache_addr_d) cache_data_d = wr_data;
    end
    always_comb begin
        busy    = state_q == FETCH;
        valid   = valid_q;
        data    = data_q;
        hit_cnt = hit_cnt_q;
    end
endmodule

// File: tb/tb_occ_table_responder.sv
// tb_occ_table_responder: directed vector table plus hand-written reset sequences
module tb_occ_table_responder;
    typedef struct {
        logic        ce;
        logic [7:0]  addr;
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        v;
        logic        b;
        logic [31:0] d;
        logic [15:0] h;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] data;
    logic        valid;
    logic        busy;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [15:0] hit_cnt;
    int          n_tests = 0;
    int          n_fail = 0;
    vec_t        tv[$];
    int          mark;
    occ_table_responder dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .data(data), .valid(valid),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hit_cnt(hit_cnt)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic c, input logic [7:0] a, input logic w, input logic [7:0] wa,
                                input logic [31:0] wd, input logic v, input logic b,
                                input logic [31:0] d, input logic [15:0] h);
        mk = '{c, a, w, wa, wd, v, b, d, h};
    endfunction
    task automatic check(input string name, input logic v, input logic b, input logic [31:0] d,
                         input logic [15:0] h, input logic chk_d);
        n_tests++;
        if (valid !== v || busy !== b || hit_cnt !== h || (chk_d && data !== d)) begin
            n_fail++;
            $display("FAIL %s: got valid=%b busy=%b data=%h hit_cnt=%0d, required valid=%b busy=%b data=%h hit_cnt=%0d",
                     name, valid, busy, data, hit_cnt, v, b, d, h);
        end
    endtask
    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            ce = tv[i].ce;
            addr = tv[i].addr;
            wr_en = tv[i].we;
            wr_addr = tv[i].wa;
            wr_data = tv[i].wd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tv[i].v, tv[i].b, tv[i].d, tv[i].h, tv[i].v);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
    initial begin
        // load, first miss (busy 3 cycles), repeat hit
        tv.push_back(mk(0, 8'h05, 1, 8'h05, 32'h1234_5678, 0, 0, 0, 0));
        tv.push_back(mk(0, 8'h05, 1, 8'h06, 32'hAAAA_5555, 0, 0, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 1, 0, 32'h1234_5678, 0));
        tv.push_back(mk(0, 8'h05, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 1, 0, 32'h1234_5678, 1));
        // address switch in HOLD -> miss to 0x06
        tv.push_back(mk(1, 8'h06, 0, 0, 0, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'h06, 0, 0, 0, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'h06, 0, 0, 0, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'h06, 0, 0, 0, 1, 0, 32'hAAAA_5555, 1));
        // write in HOLD, then hit sees the written-through value
        tv.push_back(mk(1, 8'h06, 1, 8'h06, 32'h0000_0001, 1, 0, 32'h0000_0001, 1));
        tv.push_back(mk(0, 8'h06, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 8'h06, 0, 0, 0, 1, 0, 32'h0000_0001, 2));
        tv.push_back(mk(0, 8'h06, 0, 0, 0, 0, 0, 0, 2));
        // write conflict on the 2nd FETCH cycle stalls the fetch
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 2));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 2));
        tv.push_back(mk(1, 8'h07, 1, 8'h07, 32'hDEAD_BEEF, 0, 1, 0, 2));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 2));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 2));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 2));
        tv.push_back(mk(0, 8'h07, 0, 0, 0, 0, 0, 0, 2));
        // abort mid-FETCH leaves the cache on 0x07
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 0, 2));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 0, 2));
        tv.push_back(mk(0, 8'h05, 0, 0, 0, 0, 0, 0, 2));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 3));
        mark = tv.size();
        // after reset: same address is a full miss; FETCH restart onto the cached address hits
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0));
        tv.push_back(mk(0, 8'h07, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 1));
        tv.push_back(mk(1, 8'h07, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 1));
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        run(0, mark);
        // asynchronous reset while holding 0x07
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 0, 0, 0, 0, 1);
        @(negedge clk);
        ce = 1'b0;
        rst = 1'b0;
        run(mark, tv.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
